// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode-stage RAW hazard controller.
// Tracks pending writes to x1..x31 with small down-counters, stalls decode
// while a source register is not yet readable, holds issue off around a
// flush, and keeps a saturating count of stall cycles.
// Optional feature macro: FORWARDING_EN (hazards use the forwarding-ready
// counters instead of the writeback counters).
module issue_scoreboard #(
    parameter int ALU_LAT      = 1,
    parameter int LOAD_LAT     = 2,
    parameter int WB_LAT       = 4,
    parameter int FLUSH_BUBBLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_wr_rd,
    input  logic        dec_is_load,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic [31:0] busy_mask,
    output logic [31:0] stall_count
);

    // Reload values: a consumer issued k cycles later sees LAT-k.
    localparam logic [2:0] WB_INIT   = 3'(WB_LAT - 1);
    localparam logic [2:0] BUB_INIT  = 3'(FLUSH_BUBBLE);
    localparam logic       PARAMS_OK = (ALU_LAT >= 1) && (ALU_LAT <= LOAD_LAT) &&
                                       (LOAD_LAT <= WB_LAT) && (WB_LAT <= 8);

    logic [2:0] wb_cnt [32];
    logic [2:0] bubble;
    logic [2:0] rdy_rs1;
    logic [2:0] rdy_rs2;
    logic       haz_rs1;
    logic       haz_rs2;
    logic       load_rd;
    logic [1:0] unused_cfg;

    // A source is hazardous when it is read, is not x0, and its counter is live.
    function automatic logic is_hazard(input logic use_rs, input logic [4:0] rs,
                                       input logic [2:0] cnt);
        return use_rs && (rs != 5'd0) && (cnt != 3'd0);
    endfunction

`ifdef FORWARDING_EN
    localparam logic [2:0] ALU_INIT  = 3'(ALU_LAT - 1);
    localparam logic [2:0] LOAD_INIT = 3'(LOAD_LAT - 1);

    logic [2:0] fwd_cnt [32];

    assign rdy_rs1 = fwd_cnt[dec_rs1];
    assign rdy_rs2 = fwd_cnt[dec_rs2];

    // Forwarding-ready counters: reload on a writing issue, otherwise drain.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) fwd_cnt[r] <= 3'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (r == 0)
                    fwd_cnt[r] <= 3'd0;
                else if (load_rd && (dec_rd == 5'(r)))
                    fwd_cnt[r] <= dec_is_load ? LOAD_INIT : ALU_INIT;
                else if (fwd_cnt[r] != 3'd0)
                    fwd_cnt[r] <= fwd_cnt[r] - 3'd1;
            end
        end
    end
`else
    assign rdy_rs1 = wb_cnt[dec_rs1];
    assign rdy_rs2 = wb_cnt[dec_rs2];
`endif

    // Load type and latency legality only matter with forwarding enabled.
    assign unused_cfg = {dec_is_load, PARAMS_OK};

    assign haz_rs1 = is_hazard(dec_use_rs1, dec_rs1, rdy_rs1);
    assign haz_rs2 = is_hazard(dec_use_rs2, dec_rs2, rdy_rs2);
    assign stall   = dec_valid & (haz_rs1 | haz_rs2);
    assign issue   = dec_valid & ~stall & ~flush & (bubble == 3'd0);
    assign load_rd = issue & dec_wr_rd & (dec_rd != 5'd0);

    // Writeback counters: a new producer overrides the decrement (in-order,
    // so the new value never shrinks the window and WAW is covered).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) wb_cnt[r] <= 3'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (r == 0)
                    wb_cnt[r] <= 3'd0;
                else if (load_rd && (dec_rd == 5'(r)))
                    wb_cnt[r] <= WB_INIT;
                else if (wb_cnt[r] != 3'd0)
                    wb_cnt[r] <= wb_cnt[r] - 3'd1;
            end
        end
    end

    // Post-flush bubble: armed on the flush edge, then counts down to zero.
    always_ff @(posedge clock) begin
        if (reset)
            bubble <= 3'd0;
        else if (flush)
            bubble <= BUB_INIT;
        else if (bubble != 3'd0)
            bubble <= bubble - 3'd1;
    end

    // Saturating performance counter of stalled cycles.
    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= 32'd0;
        else if (stall && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end

    // A register is busy until the register file holds its pending result.
    always_comb begin
        busy_mask = 32'd0;
        for (int r = 1; r < 32; r++) busy_mask[r] = (wb_cnt[r] != 3'd0);
    end

endmodule
